exe_pipe_ctrl: RTL and testbench

EXE_PIPE_CTRL -- requirements
Module: exe_pipe_ctrl

---
 rtl/exe_pipe_ctrl_pkg.sv | 16 +
 rtl/exe_pipe_ctrl_if.sv | 51 +++++
 rtl/exe_pipe_ctrl_fwd_sel.sv | 43 ++++
 rtl/exe_pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_exe_pipe_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pipe_ctrl_pkg.sv
// Shared CPU definitions for the execute pipeline controller:
// register-address width and operand forwarding-source encodings.
package exe_pipe_ctrl_pkg;

    localparam int REGW = 6;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/exe_pipe_ctrl_if.sv
// Decode/memory-side bundle of the execute pipeline controller.
// master drives decode/memory inputs, slave is the controller.
interface exe_pipe_ctrl_if #(
    parameter int REGW = exe_pipe_ctrl_pkg::REGW
);

    logic            fe_valid_in;
    logic            flush;
    logic [REGW-1:0] de_rs1_addr;
    logic [REGW-1:0] de_rs2_addr;
    logic            de_rs1_used;
    logic            de_rs2_used;
    logic            de_reg_en;
    logic            de_mem_read;
    logic [REGW-1:0] de_reg_waddr;
    logic            mem_data_ok;

    logic            de_valid;
    logic            exe_valid;
    logic            mem_valid;
    logic            wb_valid;
    logic            fe_allowin;
    logic            exe_bubble;
    logic            mem_wait;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [15:0]     stall_cycles;

    modport master (
        output fe_valid_in, flush,
        output de_rs1_addr, de_rs2_addr,
        output de_rs1_used, de_rs2_used,
        output de_reg_en, de_mem_read, de_reg_waddr,
        output mem_data_ok,
        input  de_valid, exe_valid, mem_valid, wb_valid,
        input  fe_allowin, exe_bubble, mem_wait,
        input  fwd_a_sel, fwd_b_sel, stall_cycles
    );

    modport slave (
        input  fe_valid_in, flush,
        input  de_rs1_addr, de_rs2_addr,
        input  de_rs1_used, de_rs2_used,
        input  de_reg_en, de_mem_read, de_reg_waddr,
        input  mem_data_ok,
        output de_valid, exe_valid, mem_valid, wb_valid,
        output fe_allowin, exe_bubble, mem_wait,
        output fwd_a_sel, fwd_b_sel, stall_cycles
    );

endinterface

// File: rtl/exe_pipe_ctrl_fwd_sel.sv
// Per-operand bypass source select: youngest producer wins,
// a load still in execute is never a source.
module fwd_sel #(
    parameter int W = 6
) (
    input  logic         de_valid,
    input  logic         used,
    input  logic [W-1:0] src,
    input  logic         exe_valid,
    input  logic         exe_reg_en,
    input  logic         exe_mem_read,
    input  logic [W-1:0] exe_waddr,
    input  logic         mem_valid,
    input  logic         mem_reg_en,
    input  logic [W-1:0] mem_waddr,
    input  logic         wb_valid,
    input  logic         wb_reg_en,
    input  logic [W-1:0] wb_waddr,
    output logic [1:0]   sel
);

    import exe_pipe_ctrl_pkg::*;

    logic exe_hit;
    logic mem_hit;
    logic wb_hit;
    logic active;

    always_comb begin
        active  = de_valid & used & (src != '0);
        exe_hit = exe_valid & exe_reg_en & ~exe_mem_read
                & (exe_waddr == src);
        mem_hit = mem_valid & mem_reg_en & (mem_waddr == src);
        wb_hit  = wb_valid & wb_reg_en & (wb_waddr == src);
        sel     = FWD_RF;
        if (active) begin
            if (exe_hit)      sel = FWD_EXE;
            else if (mem_hit) sel = FWD_MEM;
            else if (wb_hit)  sel = FWD_WB;
        end
    end

endmodule

// File: rtl/exe_pipe_ctrl.sv
// Execute pipeline controller: stage occupancy, load-use stall,
// memory-wait freeze, operand forwarding and stall counting.
module exe_pipe_ctrl #(
    parameter int REGW = exe_pipe_ctrl_pkg::REGW
) (
    input logic            clk,
    input logic            resetn,
    exe_pipe_ctrl_if.slave bus
);

    import exe_pipe_ctrl_pkg::*;

    typedef struct packed {
        logic            reg_en;
        logic            mem_read;
        logic [REGW-1:0] waddr;
    } tag_t;

    logic        de_valid_q,  de_valid_d;
    logic        exe_valid_q, exe_valid_d;
    logic        mem_valid_q, mem_valid_d;
    logic        wb_valid_q,  wb_valid_d;
    tag_t        exe_q, exe_d;
    tag_t        mem_q, mem_d;
    tag_t        wb_q,  wb_d;
    logic [15:0] stall_q, stall_d;

    tag_t de_tag;
    logic mem_wait;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic lu_stall;

    always_comb begin
        de_tag   = '{reg_en:   bus.de_reg_en,
                     mem_read: bus.de_mem_read,
                     waddr:    bus.de_reg_waddr};
        mem_wait = mem_valid_q & mem_q.mem_read & ~bus.mem_data_ok;
        rs1_hit  = bus.de_rs1_used & (bus.de_rs1_addr == exe_q.waddr);
        rs2_hit  = bus.de_rs2_used & (bus.de_rs2_addr == exe_q.waddr);
        load_use = de_valid_q & exe_valid_q & exe_q.mem_read
                 & (exe_q.waddr != '0) & (rs1_hit | rs2_hit);
        // A redirect cancels the dependent, so it cannot stall.
        lu_stall = load_use & ~bus.flush;
    end

    always_comb begin
        de_valid_d  = de_valid_q;
        exe_valid_d = exe_valid_q;
        mem_valid_d = mem_valid_q;
        wb_valid_d  = wb_valid_q;
        exe_d       = exe_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_d     = stall_q;
        if (mem_wait) begin
            de_valid_d = de_valid_q;
        end else if (lu_stall) begin
            exe_valid_d = 1'b0;
            exe_d       = '0;
            mem_valid_d = exe_valid_q;
            mem_d       = exe_q;
            wb_valid_d  = mem_valid_q;
            wb_d        = mem_q;
        end else begin
            de_valid_d  = bus.fe_valid_in & ~bus.flush;
            exe_valid_d = de_valid_q & ~bus.flush;
            exe_d       = de_tag;
            mem_valid_d = exe_valid_q;
            mem_d       = exe_q;
            wb_valid_d  = mem_valid_q;
            wb_d        = mem_q;
        end
        if ((mem_wait | lu_stall) && stall_q != STALL_MAX)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_valid_q  <= 1'b0;
            exe_valid_q <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_q     <= '0;
        end else begin
            de_valid_q  <= de_valid_d;
            exe_valid_q <= exe_valid_d;
            mem_valid_q <= mem_valid_d;
            wb_valid_q  <= wb_valid_d;
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_q     <= stall_d;
        end
    end

    fwd_sel #(.W(REGW)) u_fwd_a (
        .de_valid     (de_valid_q),
        .used         (bus.de_rs1_used),
        .src          (bus.de_rs1_addr),
        .exe_valid    (exe_valid_q),
        .exe_reg_en   (exe_q.reg_en),
        .exe_mem_read (exe_q.mem_read),
        .exe_waddr    (exe_q.waddr),
        .mem_valid    (mem_valid_q),
        .mem_reg_en   (mem_q.reg_en),
        .mem_waddr    (mem_q.waddr),
        .wb_valid     (wb_valid_q),
        .wb_reg_en    (wb_q.reg_en),
        .wb_waddr     (wb_q.waddr),
        .sel          (bus.fwd_a_sel)
    );

    fwd_sel #(.W(REGW)) u_fwd_b (
        .de_valid     (de_valid_q),
        .used         (bus.de_rs2_used),
        .src          (bus.de_rs2_addr),
        .exe_valid    (exe_valid_q),
        .exe_reg_en   (exe_q.reg_en),
        .exe_mem_read (exe_q.mem_read),
        .exe_waddr    (exe_q.waddr),
        .mem_valid    (mem_valid_q),
        .mem_reg_en   (mem_q.reg_en),
        .mem_waddr    (mem_q.waddr),
        .wb_valid     (wb_valid_q),
        .wb_reg_en    (wb_q.reg_en),
        .wb_waddr     (wb_q.waddr),
        .sel          (bus.fwd_b_sel)
    );

    assign bus.de_valid     = de_valid_q;
    assign bus.exe_valid    = exe_valid_q;
    assign bus.mem_valid    = mem_valid_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.mem_wait     = mem_wait;
    assign bus.fe_allowin   = ~mem_wait & ~lu_stall;
    assign bus.exe_bubble   = ~mem_wait & lu_stall;
    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Bench for exe_pipe_ctrl: directed vector table, random run
// against a stage-list model, reset and saturation sequences.
module tb_exe_pipe_ctrl;

    typedef struct packed {
        logic       fe, fl;
        logic [5:0] r1, r2;
        logic       u1, u2, re, mr;
        logic [5:0] wa;
        logic       ok;
    } in_t;

    typedef struct packed {
        logic        dv, ev, mv, wv, alw, bub, mw;
        logic [1:0]  fa, fb;
        logic [15:0] st;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    typedef struct {
        bit v;
        bit re;
        bit mr;
        int wa;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    exe_pipe_ctrl_if #(.REGW(6)) bus ();

    exe_pipe_ctrl #(.REGW(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    vec_t tbl [22];
    ent_t pipe [4];
    int   scnt;

    function automatic in_t mi(bit fe, bit fl, int r1, int r2,
                               bit u1, bit u2, bit re, bit mr,
                               int wa, bit ok);
        in_t x;
        x.fe = fe; x.fl = fl;
        x.r1 = r1[5:0]; x.r2 = r2[5:0];
        x.u1 = u1; x.u2 = u2; x.re = re; x.mr = mr;
        x.wa = wa[5:0]; x.ok = ok;
        return x;
    endfunction

    function automatic out_t mo(bit dv, bit ev, bit mv, bit wv,
                                bit alw, bit bub, bit mw,
                                int fa, int fb, int st);
        out_t x;
        x.dv = dv; x.ev = ev; x.mv = mv; x.wv = wv;
        x.alw = alw; x.bub = bub; x.mw = mw;
        x.fa = fa[1:0]; x.fb = fb[1:0]; x.st = st[15:0];
        return x;
    endfunction

    function automatic string fmt(out_t x);
        return $sformatf("v=%b%b%b%b alw=%b bub=%b mw=%b fa=%0d fb=%0d st=%0d",
                         x.dv, x.ev, x.mv, x.wv, x.alw, x.bub, x.mw,
                         x.fa, x.fb, x.st);
    endfunction

    function automatic out_t sample();
        out_t x;
        x.dv = bus.de_valid;   x.ev = bus.exe_valid;
        x.mv = bus.mem_valid;  x.wv = bus.wb_valid;
        x.alw = bus.fe_allowin; x.bub = bus.exe_bubble;
        x.mw = bus.mem_wait;
        x.fa = bus.fwd_a_sel;  x.fb = bus.fwd_b_sel;
        x.st = bus.stall_cycles;
        return x;
    endfunction

    task automatic apply(input in_t x);
        bus.fe_valid_in  = x.fe;
        bus.flush        = x.fl;
        bus.de_rs1_addr  = x.r1;
        bus.de_rs2_addr  = x.r2;
        bus.de_rs1_used  = x.u1;
        bus.de_rs2_used  = x.u2;
        bus.de_reg_en    = x.re;
        bus.de_mem_read  = x.mr;
        bus.de_reg_waddr = x.wa;
        bus.mem_data_ok  = x.ok;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Leaves a load to $5 alone in the mem stage, nothing else valid.
    task automatic load_to_mem();
        apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        apply(mi(0, 0, 0, 0, 0, 0, 1, 1, 5, 1));
        @(posedge clk); #1;
        apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
    endtask

    function automatic int mfwd(bit used, int src);
        if (!pipe[0].v || !used || src == 0) return 0;
        for (int s = 1; s <= 3; s++)
            if (pipe[s].v && pipe[s].re && pipe[s].wa == src
                && !(s == 1 && pipe[s].mr))
                return s;
        return 0;
    endfunction

    task automatic model_step(input in_t x, output out_t e);
        bit mw, hz, stall;
        pipe[0].re = x.re;
        pipe[0].mr = x.mr;
        pipe[0].wa = int'(x.wa);
        mw = pipe[2].v && pipe[2].mr && !x.ok;
        hz = pipe[0].v && pipe[1].v && pipe[1].mr && pipe[1].wa != 0
             && ((x.u1 && int'(x.r1) == pipe[1].wa)
              || (x.u2 && int'(x.r2) == pipe[1].wa));
        stall = hz && !x.fl;
        e = mo(pipe[0].v, pipe[1].v, pipe[2].v, pipe[3].v,
               !mw && !stall, !mw && stall, mw,
               mfwd(x.u1, int'(x.r1)), mfwd(x.u2, int'(x.r2)), scnt);
        if ((mw || stall) && scnt < 65535) scnt++;
        if (mw) return;
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        if (stall) begin
            pipe[1].v = 0;
        end else begin
            pipe[1] = pipe[0];
            pipe[1].v = pipe[0].v && !x.fl;
            pipe[0].v = x.fe && !x.fl;
        end
    endtask

    initial begin
        in_t  ri;
        out_t ro;

        tbl[0]  = '{mi(1,0,0,0,0,0,0,0,0,1),  mo(0,0,0,0,1,0,0,0,0,0)};
        tbl[1]  = '{mi(1,0,2,0,1,0,1,1,5,1),  mo(1,0,0,0,1,0,0,0,0,0)};
        tbl[2]  = '{mi(1,0,5,4,1,1,1,0,3,1),  mo(1,1,0,0,0,1,0,0,0,0)};
        tbl[3]  = '{mi(1,0,5,4,1,1,1,0,3,1),  mo(1,0,1,0,1,0,0,2,0,1)};
        tbl[4]  = '{mi(1,0,1,3,1,1,1,0,7,1),  mo(1,1,0,1,1,0,0,0,1,1)};
        tbl[5]  = '{mi(1,0,0,0,0,0,1,0,7,1),  mo(1,1,1,0,1,0,0,0,0,1)};
        tbl[6]  = '{mi(1,0,7,3,1,1,1,0,0,1),  mo(1,1,1,1,1,0,0,1,3,1)};
        tbl[7]  = '{mi(1,0,0,7,1,1,0,0,0,1),  mo(1,1,1,1,1,0,0,0,2,1)};
        tbl[8]  = '{mi(1,0,1,0,1,0,1,1,9,1),  mo(1,1,1,1,1,0,0,0,0,1)};
        tbl[9]  = '{mi(1,0,2,2,1,1,1,0,10,1), mo(1,1,1,1,1,0,0,0,0,1)};
        tbl[10] = '{mi(1,0,9,10,1,1,0,0,0,0), mo(1,1,1,1,0,0,1,2,1,1)};
        tbl[11] = '{mi(1,0,9,10,1,1,0,0,0,0), mo(1,1,1,1,0,0,1,2,1,2)};
        tbl[12] = '{mi(1,1,9,10,1,1,0,0,0,0), mo(1,1,1,1,0,0,1,2,1,3)};
        tbl[13] = '{mi(1,0,9,10,1,1,0,0,0,1), mo(1,1,1,1,1,0,0,2,1,4)};
        tbl[14] = '{mi(1,0,0,0,0,0,1,1,12,1), mo(1,1,1,1,1,0,0,0,0,4)};
        tbl[15] = '{mi(1,1,12,0,1,0,1,0,13,1),mo(1,1,1,1,1,0,0,0,0,4)};
        tbl[16] = '{mi(0,0,0,0,0,0,0,0,0,1),  mo(0,0,1,1,1,0,0,0,0,4)};
        tbl[17] = '{mi(0,0,0,0,0,0,0,0,0,1),  mo(0,0,0,1,1,0,0,0,0,4)};
        tbl[18] = '{mi(1,0,0,0,0,0,0,0,0,1),  mo(0,0,0,0,1,0,0,0,0,4)};
        tbl[19] = '{mi(1,0,0,0,0,0,1,1,0,1),  mo(1,0,0,0,1,0,0,0,0,4)};
        tbl[20] = '{mi(1,0,0,0,1,1,0,0,0,1),  mo(1,1,0,0,1,0,0,0,0,4)};
        tbl[21] = '{mi(0,0,0,0,0,0,0,0,0,1),  mo(1,1,1,0,1,0,0,0,0,4)};

        resetn = 1'b0;
        apply(mi(1, 0, 3, 3, 1, 1, 1, 1, 3, 0));
        #2;
        check("reset_outputs", mo(0,0,0,0,1,0,0,0,0,0));
        @(posedge clk); #1;
        check("reset_holds_edge", mo(0,0,0,0,1,0,0,0,0,0));
        do_reset();

        for (int k = 0; k < 22; k++) begin
            apply(tbl[k].i);
            @(negedge clk);
            check($sformatf("vec%0d", k), tbl[k].o);
            @(posedge clk); #1;
        end

        // Random traffic against the stage-list model
        do_reset();
        for (int s = 0; s < 4; s++) pipe[s] = '{0, 0, 0, 0};
        scnt = 0;
        for (int n = 0; n < 3000; n++) begin
            ri.fe = ($urandom_range(0, 9) < 8);
            ri.fl = ($urandom_range(0, 9) < 1);
            ri.r1 = 6'($urandom_range(0, 3));
            ri.r2 = 6'($urandom_range(0, 3));
            ri.u1 = 1'($urandom_range(0, 1));
            ri.u2 = 1'($urandom_range(0, 1));
            ri.re = ($urandom_range(0, 9) < 7);
            ri.mr = ($urandom_range(0, 9) < 4);
            ri.wa = 6'($urandom_range(0, 3));
            ri.ok = ($urandom_range(0, 9) < 7);
            apply(ri);
            @(negedge clk);
            model_step(ri, ro);
            check($sformatf("rand%0d", n), ro);
            @(posedge clk); #1;
        end

        // Reset while the pipeline is frozen on a memory wait
        do_reset();
        load_to_mem();
        apply(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("wait_before_reset", mo(0,0,1,0,0,0,1,0,0,0));
        @(posedge clk); #1;
        check("wait_one_stall", mo(0,0,1,0,0,0,1,0,0,1));
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_mid_wait", mo(0,0,0,0,1,0,0,0,0,0));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("first_edge_after_reset", mo(1,0,0,0,1,0,0,0,0,0));

        // Counter saturation under a long memory wait
        do_reset();
        load_to_mem();
        apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (65535) @(posedge clk);
        #1;
        check("stall_reaches_max", mo(0,0,1,0,0,0,1,0,0,65535));
        repeat (3) @(posedge clk);
        #1;
        check("stall_saturated", mo(0,0,1,0,0,0,1,0,0,65535));
        apply(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        check("wait_released", mo(0,0,0,1,1,0,0,0,0,65535));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
